ft_sync_tx: RTL and testbench

FT_SYNC_TX -- requirements
Module: ft_sync_tx

---
 rtl/ft_pkg.sv | 16 +
 rtl/byte_fifo.sv | 51 +++++
 rtl/ft_sync_tx.sv | 132 +++++++++++++
 tb/tb_ft_sync_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// FT245-style synchronous FIFO interface: shared types and constants.
// Holds the transmit FSM state type and the FT bus byte width.
package ft_pkg;

  localparam int FT_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    TURN,
    WRITE,
    SIWU,
    RELEASE
  } ft_tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Register-array byte FIFO with combinational head read.
// Ports: clk, rst (async, high), push_i/data_i, pop_i, head_o, level_o.
module byte_fifo
  import ft_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [FT_DATA_W-1:0]   data_i,
  input  logic                   pop_i,
  output logic [FT_DATA_W-1:0]   head_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [FT_DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_q, wr_d;
  logic [AW-1:0]        rd_q, rd_d;
  logic [AW:0]          level_q, level_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d    = push_i ? wr_q + AW'(1) : wr_q;
    rd_d    = pop_i  ? rd_q + AW'(1) : rd_q;
    level_d = level_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: level_q gates visibility.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign level_o = level_q;

endmodule

// File: rtl/ft_sync_tx.sv
// FT synchronous-FIFO transmit engine: buffers bytes, arbitrates for
// the shared ft_data bus, strobes ft_wrn per byte, optional SIWU.
// Ports: clk, rst, s_data/s_valid/s_ready, flush, bus_req/bus_gnt,
// ft_txen, ft_wrn, ft_siwu, ft_data_out, ft_data_oe, fifo_level.
module ft_sync_tx
  import ft_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int MAX_STALL = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FT_DATA_W-1:0]   s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   flush,
  output logic                   bus_req,
  input  logic                   bus_gnt,
  input  logic                   ft_txen,
  output logic                   ft_wrn,
  output logic                   ft_siwu,
  output logic [FT_DATA_W-1:0]   ft_data_out,
  output logic                   ft_data_oe,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(MAX_STALL + 1);

  ft_tx_state_t  state_q, state_d;
  logic          wrn_q, wrn_d;
  logic          flush_q, flush_d;
  logic [SW-1:0] stall_q, stall_d;

  logic          push, pop, remain;
  logic [LW-1:0] lvl_nxt;

  assign s_ready = fifo_level < LW'(DEPTH);
  assign push    = s_valid & s_ready;
  // The chip takes a byte exactly when the strobe meets room.
  assign pop     = ~wrn_q & ~ft_txen;
  assign lvl_nxt = fifo_level + LW'(push) - LW'(pop);
  assign remain  = lvl_nxt != '0;
  assign ft_wrn  = wrn_q;

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .data_i (s_data),
    .pop_i  (pop),
    .head_o (ft_data_out),
    .level_o(fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    wrn_d      = 1'b1;
    stall_d    = '0;
    flush_d    = flush_q | flush;
    bus_req    = 1'b0;
    ft_data_oe = 1'b0;
    ft_siwu    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (fifo_level != '0 || flush_q) state_d = REQ;
      end
      REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) state_d = TURN;
      end
      TURN: begin
        bus_req    = 1'b1;
        ft_data_oe = 1'b1;
        if (!bus_gnt) begin
          state_d = IDLE;
        end else begin
          state_d = WRITE;
          wrn_d   = ~remain;
        end
      end
      WRITE: begin
        bus_req    = 1'b1;
        ft_data_oe = 1'b1;
        stall_d    = ft_txen ? stall_q + SW'(1) : '0;
        if (!bus_gnt) begin
          state_d = IDLE;
        end else if (!remain) begin
          state_d = flush_q ? SIWU : RELEASE;
        end else if (stall_d == SW'(MAX_STALL)) begin
          state_d = RELEASE;
        end else begin
          wrn_d = 1'b0;
        end
      end
      SIWU: begin
        bus_req    = 1'b1;
        ft_data_oe = 1'b1;
        ft_siwu    = 1'b0;
        if (!bus_gnt) begin
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
          flush_d = flush;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wrn_q   <= 1'b1;
      flush_q <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wrn_q   <= wrn_d;
      flush_q <= flush_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_ft_sync_tx.sv
// Scoreboard bench for ft_sync_tx: expected bytes and SIWU events are
// queued at stimulus time and popped by a bus-side monitor.
module tb_ft_sync_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       flush = 1'b0;
  logic       bus_gnt = 1'b0;
  logic       ft_txen = 1'b1;
  logic       s_ready, bus_req, ft_wrn, ft_siwu, ft_data_oe;
  logic [7:0] ft_data_out;
  logic [3:0] fifo_level;

  ft_sync_tx #(
    .DEPTH(8),
    .MAX_STALL(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .flush      (flush),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .ft_txen    (ft_txen),
    .ft_wrn     (ft_wrn),
    .ft_siwu    (ft_siwu),
    .ft_data_out(ft_data_out),
    .ft_data_oe (ft_data_oe),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_siwu;
    logic [7:0] d;
  } ev_t;

  ev_t sb[$];
  ev_t e;
  int  errors = 0;
  int  checks = 0;
  int  strobes = 0;
  int  stall_cnt = 0;
  int  siwu_cnt = 0;
  int  turn_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, i.e. the values the next edge will see.
  always @(negedge clk) begin
    if (!rst) begin
      if (ft_data_oe && ft_wrn && ft_siwu) turn_cnt++;
      if (!ft_wrn) begin
        if (!ft_txen) begin
          strobes++;
          if (sb.size() == 0) begin
            chk("unexpected_strobe", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("strobe_byte", {23'd0, 1'b0, ft_data_out},
                {23'd0, e.is_siwu, e.d});
            chk("strobe_oe", ft_data_oe, 1);
          end
        end else begin
          stall_cnt++;
          if (sb.size() > 0)
            chk("stall_hold", ft_data_out, sb[0].d);
        end
      end
      if (!ft_siwu) begin
        siwu_cnt++;
        chk("siwu_wrn_high", ft_wrn, 1);
        if (sb.size() == 0) begin
          chk("unexpected_siwu", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("siwu_event", e.is_siwu, 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    strobes   = 0;
    stall_cnt = 0;
    siwu_cnt  = 0;
    turn_cnt  = 0;
  endtask

  task automatic push(input logic [7:0] b, input bit f);
    chk("s_ready_before_push", s_ready, 1);
    s_data  = b;
    s_valid = 1'b1;
    flush   = f;
    sb.push_back('{1'b0, b});
    if (f) sb.push_back('{1'b1, 8'h00});
    tick();
    s_valid = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (!(sb.size() == 0 && !bus_req && fifo_level == 0)
           && n < max) begin
      tick();
      n++;
    end
    if (n >= max) chk("drain_timeout", 1, 0);
    repeat (2) tick();
  endtask

  task automatic wait_strobes(input int cnt);
    int n = 0;
    while (strobes < cnt && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("strobe_timeout", 1, 0);
  endtask

  initial begin
    int n;
    tick();
    chk("rst_wrn", ft_wrn, 1);
    chk("rst_siwu", ft_siwu, 1);
    chk("rst_oe", ft_data_oe, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_s_ready", s_ready, 1);
    rst = 1'b0;
    tick();

    // Three-byte burst, chip always ready.
    bus_gnt = 1'b1;
    ft_txen = 1'b0;
    clr();
    push(8'h11, 0);
    push(8'h22, 0);
    push(8'h33, 0);
    drain(100);
    chk("burst3_strobes", strobes, 3);
    chk("burst3_turn", turn_cnt, 1);
    chk("burst3_level", fifo_level, 0);

    // Two-cycle stall mid-burst.
    clr();
    push(8'h41, 0);
    push(8'h42, 0);
    push(8'h43, 0);
    push(8'h44, 0);
    wait_strobes(2);
    ft_txen = 1'b1;
    tick();
    chk("stall_level_1", fifo_level, 2);
    tick();
    chk("stall_level_2", fifo_level, 2);
    ft_txen = 1'b0;
    drain(100);
    chk("stall_strobes", strobes, 4);
    chk("stall_cycles", stall_cnt, 2);

    // Chip never ready: bus released after MAX_STALL.
    clr();
    ft_txen = 1'b1;
    push(8'h55, 0);
    push(8'h66, 0);
    n = 0;
    while (!bus_req && n < 20) begin tick(); n++; end
    n = 0;
    while (bus_req && n < 100) begin tick(); n++; end
    chk("maxstall_release", bus_req, 0);
    chk("maxstall_cycles", stall_cnt, 16);
    chk("maxstall_level", fifo_level, 2);
    n = 0;
    while (!bus_req && n < 10) begin tick(); n++; end
    chk("maxstall_rereq", bus_req, 1);
    ft_txen = 1'b0;
    drain(100);
    chk("maxstall_strobes", strobes, 2);

    // One byte plus flush.
    clr();
    push(8'hA5, 1);
    drain(100);
    chk("flush_strobes", strobes, 1);
    chk("flush_siwu", siwu_cnt, 1);

    // Flush with nothing queued.
    clr();
    flush = 1'b1;
    sb.push_back('{1'b1, 8'h00});
    tick();
    flush = 1'b0;
    drain(100);
    chk("eflush_strobes", strobes, 0);
    chk("eflush_siwu", siwu_cnt, 1);
    chk("eflush_oe_cycles", turn_cnt, 2);

    // Fill while ungranted, then push alongside a pop.
    clr();
    bus_gnt = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i), 0);
    chk("full_level", fifo_level, 8);
    chk("full_s_ready", s_ready, 0);
    chk("full_bus_req", bus_req, 1);
    bus_gnt = 1'b1;
    wait_strobes(1);
    chk("after_pop_level", fifo_level, 7);
    chk("after_pop_wrn", ft_wrn, 0);
    s_data  = 8'h99;
    s_valid = 1'b1;
    sb.push_back('{1'b0, 8'h99});
    tick();
    s_valid = 1'b0;
    chk("push_pop_level", fifo_level, 7);
    drain(100);
    chk("full_strobes", strobes, 9);

    // Asynchronous reset mid-burst.
    clr();
    push(8'hC1, 0);
    push(8'hC2, 0);
    push(8'hC3, 0);
    push(8'hC4, 0);
    wait_strobes(1);
    chk("pre_rst_wrn", ft_wrn, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wrn", ft_wrn, 1);
    chk("arst_oe", ft_data_oe, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_bus_req", bus_req, 0);
    sb.delete();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_level", fifo_level, 0);
    chk("post_rst_wrn", ft_wrn, 1);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
